// File: rtl/op_sched.sv
// Descriptor-driven scheduler for the copy/fill engines: it accepts one descriptor,
// enables the selected engine, counts written words, and reports completion status.
module op_sched #(
    parameter int LEN_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [1:0]       desc_op,
    input  logic [7:0]       desc_fill,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             abort,
    output logic [23:0]      dc,
    output logic             eng_rst,
    input  logic             m_dst_putn,
    input  logic             m_endn,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [LEN_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] OP_COPY = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ABORT = 2'b01;
    localparam logic [1:0] ST_SHORT = 2'b10;
    localparam logic [1:0] ST_BADOP = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [7:0]       fill_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       status_q, status_d;
    logic             accept;
    logic             beat;

    assign accept  = (state_q == IDLE) && desc_valid;
    assign beat    = !m_dst_putn;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            fill_q   <= 8'h00;
            len_q    <= '0;
            cnt_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            if (accept) begin
                op_q   <= desc_op;
                fill_q <= desc_fill;
                len_q  <= desc_len;
            end
        end
    end

    // Abort outranks every other exit; in RUN the current beat is still counted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (desc_valid) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    status_d = ST_OK;
                end
            end
            LOAD: begin
                state_d = RUN;
                if (abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (op_q[1]) begin
                    state_d  = DONE;
                    status_d = ST_BADOP;
                end else if (len_q == '0) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end
            end
            RUN: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                end
                if (abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (beat && (cnt_inc == len_q)) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end else if ((op_q == OP_COPY) && !m_endn) begin
                    state_d  = DONE;
                    status_d = ST_SHORT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign desc_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign eng_rst    = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign status     = status_q;
    assign xfer_cnt   = cnt_q;

    // Fill byte is presented from LOAD onward so the engine sees it before being enabled.
    always_comb begin
        dc = 24'h000000;
        if ((state_q == LOAD) || (state_q == RUN)) begin
            dc[23:16] = fill_q;
        end
        if (state_q == RUN) begin
            dc[3] = (op_q == OP_FILL);
            dc[2] = (op_q == OP_COPY);
        end
    end

endmodule

// File: tb/tb_op_sched.sv
// Randomised and directed bench for op_sched; each descriptor's outcome is predicted
// from its per-cycle stimulus before it is driven, then checked cycle by cycle.
module tb_op_sched;

    localparam int LEN_W = 16;
    localparam int MAXC  = 64;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             desc_valid;
    logic             desc_ready;
    logic [1:0]       desc_op;
    logic [7:0]       desc_fill;
    logic [LEN_W-1:0] desc_len;
    logic             abort;
    logic [23:0]      dc;
    logic             eng_rst;
    logic             m_dst_putn;
    logic             m_endn;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [LEN_W-1:0] xfer_cnt;

    int total = 0;
    int bad   = 0;

    logic putn_v [MAXC];
    logic endn_v [MAXC];
    logic abort_v[MAXC];
    logic abort_load;

    op_sched #(.LEN_W(LEN_W)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_op    (desc_op),
        .desc_fill  (desc_fill),
        .desc_len   (desc_len),
        .abort      (abort),
        .dc         (dc),
        .eng_rst    (eng_rst),
        .m_dst_putn (m_dst_putn),
        .m_endn     (m_endn),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge wb_clk_i);
    endtask

    task automatic quiet_stim();
        for (int k = 0; k < MAXC; k++) begin
            putn_v[k]  = 1'b0;
            endn_v[k]  = 1'b1;
            abort_v[k] = 1'b0;
        end
        abort_v[MAXC-1] = 1'b1;
        abort_load = 1'b0;
    endtask

    task automatic random_stim();
        for (int k = 0; k < MAXC; k++) begin
            putn_v[k]  = ($urandom_range(0, 9) < 4);
            endn_v[k]  = ($urandom_range(0, 39) != 0);
            abort_v[k] = ($urandom_range(0, 49) == 0);
        end
        abort_v[MAXC-1] = 1'b1;
        abort_load = ($urandom_range(0, 19) == 0);
    endtask

    // Reference: predicts RUN length, status and word count from the stimulus arrays.
    task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] fill, input logic [15:0] len);
        int          run_n;
        logic [15:0] cnt;
        logic [1:0]  st;
        logic [15:0] pre_cnt[MAXC];
        run_n = 0;
        cnt   = 16'h0;
        st    = 2'b00;
        if (abort_load)      st = 2'b01;
        else if (op[1])      st = 2'b11;
        else if (len == 0)   st = 2'b00;
        else begin
            for (int k = 0; k < MAXC; k++) begin
                pre_cnt[k] = cnt;
                run_n = k + 1;
                if (!putn_v[k] && cnt != 16'hffff) cnt = cnt + 16'h1;
                if (abort_v[k])                          begin st = 2'b01; break; end
                if (!putn_v[k] && cnt == len)            begin st = 2'b00; break; end
                if (op == 2'b00 && !endn_v[k])           begin st = 2'b10; break; end
            end
        end

        desc_valid = 1'b1;
        desc_op    = op;
        desc_fill  = fill;
        desc_len   = len;
        sample();
        check_output("idle_ready", desc_ready, 1);
        check_output("idle_busy", busy, 0);
        next_cycle();

        desc_valid = 1'b0;
        desc_op    = 2'($urandom);
        desc_len   = 16'($urandom);
        abort      = abort_load;
        m_dst_putn = 1'($urandom);
        m_endn     = 1'($urandom);
        sample();
        check_output("load_engrst", eng_rst, 1);
        check_output("load_dc", dc, {fill, 16'h0000});
        check_output("load_flags", {busy, desc_ready, done}, 3'b100);
        check_output("load_cnt", xfer_cnt, 0);
        next_cycle();

        for (int k = 0; k < run_n; k++) begin
            m_dst_putn = putn_v[k];
            m_endn     = endn_v[k];
            abort      = abort_v[k];
            sample();
            check_output("run_dc", dc, {fill, 12'h000, (op == 2'b01), (op == 2'b00), 2'b00});
            check_output("run_cnt", xfer_cnt, pre_cnt[k]);
            check_output("run_flags", {busy, desc_ready, done, eng_rst}, 4'b1000);
            next_cycle();
        end

        m_dst_putn = 1'($urandom);
        m_endn     = 1'($urandom);
        abort      = 1'($urandom);
        sample();
        check_output("done_pulse", {done, busy, desc_ready}, 3'b110);
        check_output("done_status", status, st);
        check_output("done_cnt", xfer_cnt, cnt);
        check_output("done_dc", dc, 0);
        next_cycle();

        m_dst_putn = 1'($urandom);
        abort      = 1'($urandom);
        sample();
        check_output("idle_after", {done, busy, desc_ready}, 3'b001);
        check_output("held_status", status, st);
        check_output("held_cnt", xfer_cnt, cnt);
        check_output("idle_dc", dc, 0);
        next_cycle();
        abort      = 1'b0;
        m_dst_putn = 1'b1;
        m_endn     = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_dc"}, dc, 0);
        check_output({tag, "_flags"}, {eng_rst, done, busy, desc_ready}, 4'b0001);
        check_output({tag, "_status"}, status, 0);
        check_output({tag, "_cnt"}, xfer_cnt, 0);
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        desc_valid = 1'b0;
        desc_op    = 2'b00;
        desc_fill  = 8'h00;
        desc_len   = '0;
        abort      = 1'b0;
        m_dst_putn = 1'b1;
        m_endn     = 1'b1;
        next_cycle();
        next_cycle();
        check_reset_values("reset");
        wb_rst_i = 1'b0;
        next_cycle();
        check_reset_values("post_reset");

        $display("[TB] fill A5 len 4");
        quiet_stim();
        apply_stimulus(2'b01, 8'hA5, 16'd4);

        $display("[TB] copy short after 3 beats");
        quiet_stim();
        putn_v[3] = 1'b1;
        endn_v[3] = 1'b0;
        apply_stimulus(2'b00, 8'h3C, 16'd8);

        $display("[TB] zero length and bad op");
        quiet_stim();
        apply_stimulus(2'b01, 8'h11, 16'd0);
        quiet_stim();
        apply_stimulus(2'b11, 8'h22, 16'd5);

        $display("[TB] abort on beat 5");
        quiet_stim();
        abort_v[4] = 1'b1;
        apply_stimulus(2'b01, 8'h5A, 16'd10);

        $display("[TB] backpressure 20 cycles");
        quiet_stim();
        for (int k = 2; k < 22; k++) putn_v[k] = 1'b1;
        apply_stimulus(2'b00, 8'h77, 16'd6);

        $display("[TB] reset mid-run after 2 beats");
        quiet_stim();
        desc_valid = 1'b1;
        desc_op    = 2'b01;
        desc_fill  = 8'hC3;
        desc_len   = 16'd10;
        next_cycle();
        desc_valid = 1'b0;
        next_cycle();
        m_dst_putn = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        check_output("pre_reset_cnt", xfer_cnt, 2);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        m_dst_putn = 1'b1;
        next_cycle();
        sample();
        wb_rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check_output("no_done_after_reset", done, 0);
        end
        next_cycle();
        quiet_stim();
        apply_stimulus(2'b01, 8'h81, 16'd3);

        $display("[TB] random descriptors");
        for (int t = 0; t < 40; t++) begin
            random_stim();
            apply_stimulus(($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1)),
                           8'($urandom), 16'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op_sched.md
OP_SCHED -- requirements
Module: op_sched

Interface
REQ-001 LEN_W, 16, descriptor length width in 64-bit words.
REQ-002 wb_clk_i  in  1  clock; all state on rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 desc_valid  in  1  descriptor offered.
REQ-005 desc_ready  out  1  scheduler can accept descriptor.
REQ-006 desc_op  in  2  operation: 00 copy, 01 fill, 10/11 reserved.
REQ-007 desc_fill  in  8  fill byte.
REQ-008 desc_len  in  LEN_W  transfer length in 64-bit words.
REQ-009 abort  in  1  terminate current operation.
REQ-010 dc  out  24  engine control word: [23:16] fill byte, [3] fill enable, [2] copy enable, all other bits 0.
REQ-011 eng_rst  out  1  one-cycle engine reset pulse.
REQ-012 m_dst_putn  in  1  active-low beat write from the selected engine.
REQ-013 m_endn  in  1  active-low source-end from the copy engine.
REQ-014 busy  out  1  operation in progress.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 status  out  2  00 ok, 01 aborted, 10 short (source ended), 11 bad op; valid with done, held until next accept.
REQ-017 xfer_cnt  out  LEN_W  words written in current/last operation.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: desc_ready=1; desc_valid&desc_ready latches op/fill/len, clears xfer_cnt and status, goes to LOAD.
REQ-020 After accept, if desc_len==0 or desc_op is 10/11: go to DONE next cycle, no dc enable, status 00 (len 0) or 11 (bad op); bad op takes precedence.
REQ-021 LOAD: lasts 1 cycle; eng_rst=1; dc enables=0; dc[23:16]=latched fill byte; then RUN.
REQ-022 RUN: dc[3]=1 for fill, dc[2]=1 for copy, exactly one set; dc[23:16] held.
REQ-023 Beat = m_dst_putn==0 sampled in RUN; each beat increments xfer_cnt by 1, saturating at 2^LEN_W-1.
REQ-024 The beat that makes xfer_cnt==len moves to DONE; dc enables SHALL drop in the next cycle, so no more than len beats are counted.
REQ-025 Beats in IDLE, LOAD, or DONE SHALL be ignored.
REQ-026 Copy op only: m_endn==0 in RUN moves to DONE, status 10, unless the same cycle's beat completes len (then status 00, that beat counted).
REQ-027 For fill op, m_endn SHALL be ignored.
REQ-028 abort==1 in LOAD or RUN moves to DONE, status 01; same-cycle beat counted; abort overrides completion and short.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 DONE: lasts 1 cycle; done=1; dc enables=0; then IDLE.
REQ-031 busy=1 in LOAD, RUN, DONE.
REQ-032 desc_ready=0 outside IDLE.
REQ-033 Accept-to-first-enable latency SHALL be 2 cycles (accept edge, LOAD cycle).
REQ-034 Last-beat-to-done latency SHALL be 1 cycle.
REQ-035 All outputs SHALL be registered or decoded from state/registers only; no combinational input-to-output path.

Reset
REQ-036 wb_rst_i SHALL force IDLE immediately, including mid-RUN.
REQ-037 Reset values: dc=0, eng_rst=0, done=0, busy=0, desc_ready=1 after release, status=00, xfer_cnt=0.
REQ-038 Reset mid-operation SHALL NOT produce a done pulse.

Verification
REQ-039 Fill: op=01, fill=A5, len=4, putn low every RUN cycle -> dc=A50008 for exactly 4 beat cycles, done one cycle later, status 00, xfer_cnt 4.
REQ-040 Copy short: op=00, len=8, m_endn low after 3 beats -> dc[2] drops, done, status 10, xfer_cnt 3.
REQ-041 Zero length and bad op: len=0 -> done 2 cycles after accept, status 00, dc never enabled; op=11 len=5 -> status 11.
REQ-042 Abort: fill len=10, abort on beat 5 -> status 01, xfer_cnt 5, dc=0 next cycle.
REQ-043 Backpressure: putn high for 20 cycles mid-RUN (engine full) -> dc stays enabled, no count change, completion resumes normally.
REQ-044 Reset in RUN after 2 beats -> all outputs to reset values asynchronously, no done, next descriptor accepted normally.
